aes_result_collector: RTL and testbench

- Downstream companion to the 128-bit pipelined AES core. The core has a fixed latency and cannot stall, so it carries no valid signal.
- This block gives the core a valid/ready interface:
  - accepts issue requests from upstream with a tag;
  - tracks in-flight transactions through a LATENCY-deep valid/tag shift line;
  - captures core_out when each transaction emerges;
  - buffers results in a FIFO with a ready/valid output.
- Credit-based issue control makes FIFO overflow impossible, even though the core cannot be back-pressured.

---
 rtl/aes_result_collector_if.sv | 26 ++
 rtl/aes_result_collector.sv | 126 ++++++++++++
 tb/tb_aes_result_collector.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_result_collector_if.sv
// Handshake bundle between the AES result collector, its upstream issuer,
// the AES core output and the downstream consumer.
interface aes_result_collector_if #(
  parameter int TAG_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [TAG_W-1:0] in_tag;
  logic [127:0]     core_out;
  logic             out_valid;
  logic             out_ready;
  logic [127:0]     out_data;
  logic [TAG_W-1:0] out_tag;

  // Collector side of the bundle.
  modport slave (
    input  in_valid, in_tag, core_out, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );

  // Environment side: upstream issuer, core output and downstream consumer.
  modport master (
    output in_valid, in_tag, core_out, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );
endinterface

// File: rtl/aes_result_collector.sv
// aes_result_collector: gives a fixed-latency, non-stallable AES core a
// valid/ready interface. Issued transactions ride a LATENCY-deep valid/tag
// line; when a transaction emerges, core_out is captured into a FWFT FIFO.
// Credits (inflight + fifo_level < DEPTH) reserve a FIFO slot for every issue,
// so a capture can never find the FIFO full unless LATENCY is misconfigured.
module aes_result_collector #(
  parameter  int LATENCY = 21,
  parameter  int DEPTH   = 32,
  parameter  int TAG_W   = 8,
  localparam int INF_W   = $clog2(LATENCY + 1),
  localparam int LVL_W   = $clog2(DEPTH + 1),
  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  aes_result_collector_if.slave bus,
  output logic [INF_W-1:0]      inflight,
  output logic [LVL_W-1:0]      fifo_level,
  output logic                  ovf_err
);

  logic [LATENCY-1:0] vline_r;
  logic [TAG_W-1:0]   tline_r    [LATENCY];
  logic [127:0]       mem_data_r [DEPTH];
  logic [TAG_W-1:0]   mem_tag_r  [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [INF_W-1:0]   inflight_r;
  logic [INF_W-1:0]   inflight_nxt_s;
  logic [LVL_W-1:0]   level_r;
  logic [LVL_W-1:0]   level_nxt_s;
  logic               in_ready_r;
  logic               out_valid_r;
  logic               ovf_r;
  logic               accept_s;
  logic               cap_s;
  logic               pop_s;
  logic               full_s;
  logic               wr_en_s;
  logic               ovf_hit_s;

  // Pointer advance modulo DEPTH; DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  // Handshake decode and next values of the occupancy counters.
  always_comb begin
    accept_s       = bus.in_valid & in_ready_r;
    cap_s          = vline_r[LATENCY-1];
    pop_s          = out_valid_r & bus.out_ready;
    full_s         = (level_r == LVL_W'(DEPTH));
    // A pop in the same edge frees the slot the capture writes into.
    wr_en_s        = cap_s & (~full_s | pop_s);
    ovf_hit_s      = cap_s & full_s & ~pop_s;
    inflight_nxt_s = inflight_r + INF_W'(accept_s) - INF_W'(cap_s);
    level_nxt_s    = level_r + LVL_W'(wr_en_s) - LVL_W'(pop_s);
  end

  // Valid/tag line, counters, pointers, credit and status registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vline_r     <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        tline_r[i] <= '0;
      end
      inflight_r  <= '0;
      level_r     <= '0;
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      ovf_r       <= 1'b0;
    end else begin
      vline_r[0] <= accept_s;
      tline_r[0] <= bus.in_tag;
      for (int i = 1; i < LATENCY; i++) begin
        vline_r[i] <= vline_r[i-1];
        tline_r[i] <= tline_r[i-1];
      end
      inflight_r  <= inflight_nxt_s;
      level_r     <= level_nxt_s;
      // Credit decision is registered so in_ready never depends on in_valid/out_ready.
      in_ready_r  <= (32'(inflight_nxt_s) + 32'(level_nxt_s)) < 32'(DEPTH);
      out_valid_r <= (level_nxt_s != '0);
      if (wr_en_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      if (ovf_hit_s) begin
        ovf_r <= 1'b1;
      end
    end
  end

  // Result storage; contents are qualified by out_valid so no reset is needed.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_data_r[wr_ptr_r] <= bus.core_out;
      mem_tag_r[wr_ptr_r]  <= tline_r[LATENCY-1];
    end
  end

  // Output drive: FWFT head, forced to zero whenever the FIFO is empty.
  always_comb begin
    bus.in_ready  = in_ready_r;
    bus.out_valid = out_valid_r;
    if (out_valid_r) begin
      bus.out_data = mem_data_r[rd_ptr_r];
      bus.out_tag  = mem_tag_r[rd_ptr_r];
    end else begin
      bus.out_data = '0;
      bus.out_tag  = '0;
    end
    inflight   = inflight_r;
    fifo_level = level_r;
    ovf_err    = ovf_r;
  end

endmodule

// File: tb/tb_aes_result_collector.sv
// Bench for aes_result_collector: a DEPTH=32 and a DEPTH=4 instance share one
// stimulus stream and a stand-in AES core (a LAT-stage delay of the known
// result of each input). Each instance is checked every cycle against a
// queue-based model, plus directed literal expectations.
module tb_aes_result_collector;
  localparam int LAT = 21;
  localparam int TW  = 8;

  typedef struct {
    logic [127:0] data;
    logic [7:0]   tag;
    int           rdy;
  } ent_t;

  logic         clk       = 1'b0;
  logic         rst       = 1'b0;
  logic         in_valid  = 1'b0;
  logic [7:0]   in_tag    = 8'h00;
  logic [127:0] core_in   = 128'h0;
  logic         out_ready = 1'b0;
  logic [127:0] core_pipe [LAT];
  logic [127:0] core_out;
  int           checks    = 0;
  int           errors    = 0;
  int           seq       = 0;

  always #5 clk = ~clk;

  task automatic chk(input string name, input int inst, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d got %h want %h", name, inst, act, exp);
    end
  endtask

  // Move to the next falling edge and present one cycle of stimulus.
  task automatic drive(input logic v, input logic [7:0] tag, input logic ordy);
    @(negedge clk);
    in_valid  = v;
    in_tag    = tag;
    out_ready = ordy;
    seq++;
    core_in   = {24'hAE5C0D, tag, 32'(seq), 64'h0123_4567_89AB_CDEF ^ {2{32'(seq)}}};
  endtask

  // Stand-in core: whatever result the current input yields appears LAT-1 edges later.
  always_ff @(posedge clk) begin
    core_pipe[0] <= core_in;
    for (int i = 1; i < LAT; i++) begin
      core_pipe[i] <= core_pipe[i-1];
    end
  end
  assign core_out = core_pipe[LAT-1];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int D  = (g == 0) ? 32 : 4;
    localparam int IW = $clog2(LAT + 1);
    localparam int LW = $clog2(D + 1);

    aes_result_collector_if #(.TAG_W(TW)) bus ();
    logic [IW-1:0] inflight;
    logic [LW-1:0] fifo_level;
    logic          ovf_err;
    ent_t          q[$];
    int            cyc = 0;

    assign bus.in_valid  = in_valid;
    assign bus.in_tag    = in_tag;
    assign bus.core_out  = core_out;
    assign bus.out_ready = out_ready;

    aes_result_collector #(.LATENCY(LAT), .DEPTH(D), .TAG_W(TW)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .inflight   (inflight),
      .fifo_level (fifo_level),
      .ovf_err    (ovf_err)
    );

    // Model: all issued, not yet popped transactions with the edge they land in the FIFO.
    initial begin : model
      bit   do_pop;
      bit   do_acc;
      ent_t e;
      forever begin
        @(posedge clk or negedge rst);
        if (!rst) begin
          q.delete();
        end else begin
          do_pop = (q.size() > 0) && (q[0].rdy <= cyc) && out_ready;
          do_acc = in_valid && (q.size() < D);
          cyc++;
          if (do_pop) void'(q.pop_front());
          if (do_acc) begin
            e.data = core_in;
            e.tag  = in_tag;
            e.rdy  = cyc + LAT;
            q.push_back(e);
          end
        end
      end
    end

    // Compare every output against the model between active edges.
    initial begin : cmp
      int nf;
      int ni;
      forever begin
        @(negedge clk);
        if (rst) begin
          nf = 0;
          ni = 0;
          for (int i = 0; i < q.size(); i++) begin
            if (q[i].rdy <= cyc) nf++;
            else ni++;
          end
          chk("m_out_valid", g, 128'(bus.out_valid), 128'(nf > 0));
          chk("m_in_ready", g, 128'(bus.in_ready), 128'(q.size() < D));
          chk("m_fifo_level", g, 128'(fifo_level), 128'(nf));
          chk("m_inflight", g, 128'(inflight), 128'(ni));
          chk("m_ovf_err", g, 128'(ovf_err), 128'(1'b0));
          if (nf > 0) begin
            chk("m_out_data", g, bus.out_data, q[0].data);
            chk("m_out_tag", g, 128'(bus.out_tag), 128'(q[0].tag));
          end
        end
      end
    end
  end

  // Hard time bound in case the stimulus sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // Directed stimulus with hand-computed expectations.
  initial begin
    int n;
    int exp_tag;
    int max_sum;
    int n_low;

    // Reset state.
    for (int i = 0; i < 3; i++) drive(1'b0, 8'h00, 1'b0);
    chk("rst_in_ready", 0, 128'(g_dut[0].bus.in_ready), 128'(1'b1));
    chk("rst_out_valid", 0, 128'(g_dut[0].bus.out_valid), 128'(1'b0));
    chk("rst_out_data", 0, g_dut[0].bus.out_data, 128'h0);
    chk("rst_inflight", 0, 128'(g_dut[0].inflight), 128'(0));
    chk("rst_fifo_level", 0, 128'(g_dut[0].fifo_level), 128'(0));
    rst = 1'b1;

    // Single issue: FIPS-197 known answer, result exactly LAT edges after accept.
    drive(1'b1, 8'h5A, 1'b1);
    core_in = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    drive(1'b0, 8'h00, 1'b1);
    n = 0;
    for (int k = 1; k < LAT; k++) begin
      drive(1'b0, 8'h00, 1'b1);
      if (g_dut[0].bus.out_valid) n++;
    end
    chk("single_early_valid", 0, 128'(n), 128'(0));
    drive(1'b0, 8'h00, 1'b1);
    chk("single_out_valid", 0, 128'(g_dut[0].bus.out_valid), 128'(1'b1));
    chk("single_out_data", 0, g_dut[0].bus.out_data, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    chk("single_out_tag", 0, 128'(g_dut[0].bus.out_tag), 128'(8'h5A));
    drive(1'b0, 8'h00, 1'b1);
    chk("single_after_valid", 0, 128'(g_dut[0].bus.out_valid), 128'(1'b0));
    chk("single_after_inflight", 0, 128'(g_dut[0].inflight), 128'(0));
    chk("single_after_level", 0, 128'(g_dut[0].fifo_level), 128'(0));

    // 40 back-to-back issues, drained at one result per cycle in tag order.
    exp_tag = 0;
    for (int i = 0; i < 40 + LAT + 10; i++) begin
      if (i < 40) begin
        drive(1'b1, 8'(i), 1'b1);
        chk("b2b_in_ready", 0, 128'(g_dut[0].bus.in_ready), 128'(1'b1));
      end else begin
        drive(1'b0, 8'h00, 1'b1);
      end
      if (g_dut[0].bus.out_valid) begin
        chk("b2b_tag", 0, 128'(g_dut[0].bus.out_tag), 128'(exp_tag));
        exp_tag++;
      end
    end
    chk("b2b_count", 0, 128'(exp_tag), 128'(40));

    // Fill with out_ready=0: exactly 32 accepts, then no credit.
    n = 0;
    for (int i = 0; i < 60; i++) begin
      drive(1'b1, 8'(100 + i), 1'b0);
      if (g_dut[0].bus.in_ready) n++;
    end
    chk("fill_accepts", 0, 128'(n), 128'(32));
    chk("fill_in_ready", 0, 128'(g_dut[0].bus.in_ready), 128'(1'b0));
    chk("fill_level", 0, 128'(g_dut[0].fifo_level), 128'(32));
    chk("fill_inflight", 0, 128'(g_dut[0].inflight), 128'(0));
    chk("fill_head_tag", 0, 128'(g_dut[0].bus.out_tag), 128'(8'd100));

    // Single-cycle pops every 22 cycles: each pop lines up with the capture of the refill.
    for (int r = 0; r < 4; r++) begin
      drive(1'b1, 8'(200 + r), 1'b1);
      for (int k = 0; k < 21; k++) begin
        drive(1'b1, 8'(200 + r), 1'b0);
        if (r == 0 && k == 0) begin
          chk("pulse_in_ready_back", 0, 128'(g_dut[0].bus.in_ready), 128'(1'b1));
          chk("pulse_level", 0, 128'(g_dut[0].fifo_level), 128'(31));
          chk("pulse_head_tag", 0, 128'(g_dut[0].bus.out_tag), 128'(8'd101));
        end
      end
    end
    chk("pulse_ovf", 0, 128'(g_dut[0].ovf_err), 128'(1'b0));

    // Drain everything.
    for (int i = 0; i < 80; i++) drive(1'b0, 8'h00, 1'b1);
    chk("drain_level", 0, 128'(g_dut[0].fifo_level), 128'(0));
    chk("drain_inflight", 0, 128'(g_dut[0].inflight), 128'(0));
    chk("drain_in_ready", 0, 128'(g_dut[0].bus.in_ready), 128'(1'b1));

    // Reset mid-stream with 10 in flight and 5 buffered.
    for (int i = 0; i < 15; i++) drive(1'b1, 8'(50 + i), 1'b0);
    for (int i = 0; i < 12; i++) drive(1'b0, 8'h00, 1'b0);
    chk("pre_rst_level", 0, 128'(g_dut[0].fifo_level), 128'(5));
    chk("pre_rst_inflight", 0, 128'(g_dut[0].inflight), 128'(10));
    #2;
    rst = 1'b0;
    #1;
    chk("async_out_valid", 0, 128'(g_dut[0].bus.out_valid), 128'(1'b0));
    chk("async_in_ready", 0, 128'(g_dut[0].bus.in_ready), 128'(1'b1));
    chk("async_out_data", 0, g_dut[0].bus.out_data, 128'h0);
    chk("async_out_tag", 0, 128'(g_dut[0].bus.out_tag), 128'(0));
    chk("async_inflight", 0, 128'(g_dut[0].inflight), 128'(0));
    chk("async_level", 0, 128'(g_dut[0].fifo_level), 128'(0));
    drive(1'b0, 8'h00, 1'b1);
    drive(1'b0, 8'h00, 1'b1);
    rst = 1'b1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      drive(1'b0, 8'h00, 1'b1);
      if (g_dut[0].bus.out_valid || g_dut[1].bus.out_valid) n++;
    end
    chk("no_stale_results", 0, 128'(n), 128'(0));

    // Continuous issue into the DEPTH=4 instance: credit-limited throughput.
    max_sum = 0;
    n_low   = 0;
    for (int i = 0; i < 70; i++) begin
      drive(1'b1, 8'(i), 1'b1);
      if (int'(g_dut[1].fifo_level) + int'(g_dut[1].inflight) > max_sum)
        max_sum = int'(g_dut[1].fifo_level) + int'(g_dut[1].inflight);
      if (!g_dut[1].bus.in_ready) n_low++;
    end
    chk("small_credit_peak", 1, 128'(max_sum), 128'(4));
    chk("small_in_ready_toggles", 1, 128'(n_low > 0), 128'(1'b1));
    for (int i = 0; i < 40; i++) drive(1'b0, 8'h00, 1'b1);
    chk("small_ovf", 1, 128'(g_dut[1].ovf_err), 128'(1'b0));
    chk("small_drained", 1, 128'(g_dut[1].fifo_level), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
